// File: rtl/timer_seq_ctrl_if.sv
// Button/display bundle for the BCD countdown sequencer.
// Button levels are synchronised to clk upstream; outputs change only on the clk edge.
interface timer_seq_ctrl_if;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_inc1;
  logic       btn_inc10;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       digit_sel;
  logic [3:0] disp_bcd;
  logic       running;
  logic       done;
  logic [1:0] state_dbg;

  modport master (
    output btn_start, btn_stop, btn_inc1, btn_inc10,
    input  tens, ones, digit_sel, disp_bcd, running, done, state_dbg
  );

  modport slave (
    input  btn_start, btn_stop, btn_inc1, btn_inc10,
    output tens, ones, digit_sel, disp_bcd, running, done, state_dbg
  );
endinterface

// File: rtl/timer_seq_ctrl.sv
// Two-digit BCD countdown sequencer: IDLE/RUN/PAUSE/DONE FSM, tick prescaler, digit mux.
// Define DONE_BLINK_EN to make done blink with a BLINK_DIV half-period while in DONE.
module timer_seq_ctrl #(
  parameter int TICK_DIV  = 10_000_000,
  parameter int MUX_BITS  = 10,
  parameter int BLINK_DIV = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  timer_seq_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_PAUSE = 2'd2, S_DONE = 2'd3} state_t;

  localparam int PW = $clog2(TICK_DIV);

  state_t          r_state, w_state_nx;
  logic [3:0]      r_tens, r_ones, w_tens_nx, w_ones_nx;
  logic [PW-1:0]   r_presc, w_presc_nx;
  logic [MUX_BITS-1:0] r_mux;
  logic            r_digit_sel;
  logic            r_start_q, r_stop_q, r_inc1_q, r_inc10_q;
  logic            w_start, w_stop, w_inc1, w_inc10, w_nz;

  assign w_start = bus.btn_start & ~r_start_q;
  assign w_stop  = bus.btn_stop  & ~r_stop_q;
  assign w_inc1  = bus.btn_inc1  & ~r_inc1_q;
  assign w_inc10 = bus.btn_inc10 & ~r_inc10_q;
  assign w_nz    = (r_tens != 4'd0) || (r_ones != 4'd0);

  always_comb begin
    w_state_nx = r_state;
    w_tens_nx  = r_tens;
    w_ones_nx  = r_ones;
    w_presc_nx = r_presc;
    case (r_state)
      S_IDLE: begin
        if (w_stop) begin
          w_tens_nx = 4'd0;
          w_ones_nx = 4'd0;
        end else if (w_start) begin
          // A start at 00 is dropped but still outranks any same-cycle increment.
          if (w_nz) begin
            w_state_nx = S_RUN;
            w_presc_nx = '0;
          end
        end else begin
          if (w_inc1)  w_ones_nx = (r_ones == 4'd9) ? 4'd0 : r_ones + 4'd1;
          if (w_inc10) w_tens_nx = (r_tens == 4'd9) ? 4'd0 : r_tens + 4'd1;
        end
      end
      S_RUN: begin
        if (w_stop) begin
          w_state_nx = S_IDLE;
          w_tens_nx  = 4'd0;
          w_ones_nx  = 4'd0;
        end else if (w_start) begin
          w_state_nx = S_PAUSE;
        end else if (r_presc == PW'(TICK_DIV - 1)) begin
          w_presc_nx = '0;
          if (r_ones != 4'd0) begin
            w_ones_nx = r_ones - 4'd1;
          end else begin
            w_ones_nx = 4'd9;
            w_tens_nx = r_tens - 4'd1;
          end
          if (r_tens == 4'd0 && r_ones == 4'd1) w_state_nx = S_DONE;
        end else begin
          w_presc_nx = r_presc + PW'(1);
        end
      end
      S_PAUSE: begin
        if (w_stop) begin
          w_state_nx = S_IDLE;
          w_tens_nx  = 4'd0;
          w_ones_nx  = 4'd0;
        end else if (w_start) begin
          w_state_nx = S_RUN;
          w_presc_nx = '0;
        end
      end
      S_DONE: begin
        if (w_stop || w_start) begin
          w_state_nx = S_IDLE;
          w_tens_nx  = 4'd0;
          w_ones_nx  = 4'd0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_tens      <= 4'd0;
      r_ones      <= 4'd0;
      r_presc     <= '0;
      r_mux       <= '0;
      r_digit_sel <= 1'b0;
      r_start_q   <= 1'b0;
      r_stop_q    <= 1'b0;
      r_inc1_q    <= 1'b0;
      r_inc10_q   <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_tens      <= w_tens_nx;
      r_ones      <= w_ones_nx;
      r_presc     <= w_presc_nx;
      r_mux       <= r_mux + MUX_BITS'(1);
      if (&r_mux) r_digit_sel <= ~r_digit_sel;
      r_start_q   <= bus.btn_start;
      r_stop_q    <= bus.btn_stop;
      r_inc1_q    <= bus.btn_inc1;
      r_inc10_q   <= bus.btn_inc10;
    end
  end

`ifdef DONE_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] r_blink;
  logic          r_blink_on;

  // done phase restarts high on every entry into DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blink    <= '0;
      r_blink_on <= 1'b0;
    end else if (w_state_nx == S_DONE && r_state != S_DONE) begin
      r_blink    <= '0;
      r_blink_on <= 1'b1;
    end else if (r_state == S_DONE) begin
      if (r_blink == BW'(BLINK_DIV - 1)) begin
        r_blink    <= '0;
        r_blink_on <= ~r_blink_on;
      end else begin
        r_blink <= r_blink + BW'(1);
      end
    end
  end

  assign bus.done = (r_state == S_DONE) && r_blink_on;
`else
  assign bus.done = (r_state == S_DONE);
`endif

  assign bus.tens      = r_tens;
  assign bus.ones      = r_ones;
  assign bus.digit_sel = r_digit_sel;
  assign bus.disp_bcd  = r_digit_sel ? r_tens : r_ones;
  assign bus.running   = (r_state == S_RUN);
  assign bus.state_dbg = r_state;
endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Directed bench for timer_seq_ctrl with TICK_DIV=4, MUX_BITS=2, BLINK_DIV=3.
module tb_timer_seq_ctrl;
  localparam int TICK_DIV  = 4;
  localparam int MUX_BITS  = 2;
  localparam int BLINK_DIV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_cyc    = 0;

  timer_seq_ctrl_if bus();

  timer_seq_ctrl #(.TICK_DIV(TICK_DIV), .MUX_BITS(MUX_BITS), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, p, i1, i10;
    logic [3:0] t, o;
    logic       r, d;
  } vec_t;

  vec_t tbl[8];

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, n_cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (!rst) n_cyc++;
  endtask

  task automatic set_btn(input logic s, input logic p, input logic i1, input logic i10);
    bus.btn_start = s;
    bus.btn_stop  = p;
    bus.btn_inc1  = i1;
    bus.btn_inc10 = i10;
  endtask

  task automatic chk(input string nm, input int et, input int eo, input logic er, input logic ed);
    logic ds;
    ds = ((n_cyc / 4) % 2) == 1;
    cmp({nm, " tens"}, 8'(bus.tens), 8'(et));
    cmp({nm, " ones"}, 8'(bus.ones), 8'(eo));
    cmp({nm, " running"}, 8'(bus.running), 8'(er));
    cmp({nm, " done"}, 8'(bus.done), 8'(ed));
    cmp({nm, " digit_sel"}, 8'(bus.digit_sel), 8'(ds));
    cmp({nm, " disp_bcd"}, 8'(bus.disp_bcd), ds ? 8'(et) : 8'(eo));
  endtask

  task automatic pulse(input logic s, input logic p, input logic i1, input logic i10);
    set_btn(s, p, i1, i10);
    step();
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  task automatic load(input int t, input int o);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < t; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < o; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic logic exp_done(input int k);
    if (k < 48) return 1'b0;
`ifdef DONE_BLINK_EN
    return (((k - 48) / BLINK_DIV) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  initial begin
    int v;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2, 1'b1, 1'b0};

    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 0, 0, 1'b0, 1'b0);
    cmp("reset state", 8'(bus.state_dbg), 8'd0);
    rst   = 1'b0;
    n_cyc = 0;

    // Table: load 12 with edge-detected presses, then start.
    for (int i = 0; i < 8; i++) begin
      set_btn(tbl[i].s, tbl[i].p, tbl[i].i1, tbl[i].i10);
      step();
      chk($sformatf("vec%0d", i), tbl[i].t, tbl[i].o, tbl[i].r, tbl[i].d);
    end

    // Countdown from 12: one tick per 4 clk, 00 and done on the same edge, then DONE.
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 60; k++) begin
      step();
      v = (k < 48) ? 12 - k / 4 : 0;
      chk($sformatf("count k%0d", k), v / 10, v % 10, k < 48, exp_done(k));
    end
    cmp("done state", 8'(bus.state_dbg), 8'd3);
    set_btn(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    chk("done stop", 0, 0, 1'b0, 1'b0);
    cmp("done stop state", 8'(bus.state_dbg), 8'd0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // ones wraps without carry into tens.
    for (int i = 0; i < 11; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    chk("wrap", 0, 1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    set_btn(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("start at 00", 0, 0, 1'b0, 1'b0);
    cmp("start at 00 state", 8'(bus.state_dbg), 8'd0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // Pause at 05 and resume with a fresh prescaler.
    load(0, 5);
    set_btn(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("run 05", 0, 5, 1'b1, 1'b0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_btn(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("pause", 0, 5, 1'b0, 1'b0);
    cmp("pause state", 8'(bus.state_dbg), 8'd2);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      chk($sformatf("paused %0d", i), 0, 5, 1'b0, 1'b0);
    end
    set_btn(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("resume", 0, 5, 1'b1, 1'b0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("resume +%0d", i), 0, 5, 1'b1, 1'b0);
    end
    step();
    chk("resume tick", 0, 4, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    chk("run stop", 0, 0, 1'b0, 1'b0);

    // start+stop together in RUN: stop wins.
    load(4, 2);
    set_btn(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("run 42", 4, 2, 1'b1, 1'b0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    set_btn(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    chk("start+stop", 0, 0, 1'b0, 1'b0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    step();

    // start+inc1 together in IDLE: start wins, value untouched.
    load(0, 3);
    set_btn(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    chk("start+inc1", 0, 3, 1'b1, 1'b0);
    set_btn(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    pulse(1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN at 37.
    load(3, 7);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    chk("run 37", 3, 7, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    n_cyc = 0;
    chk("async rst", 0, 0, 1'b0, 1'b0);
    step();
    chk("rst held", 0, 0, 1'b0, 1'b0);
    cmp("rst state", 8'(bus.state_dbg), 8'd0);
    rst   = 1'b0;
    n_cyc = 0;
    step();
    chk("post rst", 0, 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
